// File: rtl/phase_sequence_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequence_master_if
//  Description : Command/phase bundle between the control logic, the
//                phase_sequence_master and the T1/T2/T3 sequencer.
//                master modport : the controller (drives nSTART/nSTOP/status)
//                slave modport  : the control/UI side and sequencer returns
//  Signals     : cmd_start, cmd_stop, cycle_target  - commands from control
//                t1, t2, t3                         - phases from sequencer
//                n_start, n_stop                    - active-low to sequencer
//                busy, done, err, err_code          - status
//                cycle_count                        - T3 phases since start
//  Revision    : 1.0  initial release
// ============================================================================
interface phase_sequence_master_if #(
  parameter int CNT_W = 8
);
  logic             cmd_start;
  logic             cmd_stop;
  logic [CNT_W-1:0] cycle_target;
  logic             t1;
  logic             t2;
  logic             t3;
  logic             n_start;
  logic             n_stop;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  cmd_start, cmd_stop, cycle_target, t1, t2, t3,
    output n_start, n_stop, busy, done, err, err_code, cycle_count
  );

  modport slave (
    output cmd_start, cmd_stop, cycle_target, t1, t2, t3,
    input  n_start, n_stop, busy, done, err, err_code, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/phase_sequence_master.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequence_master
//  Description : Command-side controller for the three-phase T1->T2->T3
//                sequencer. Starts the sequencer via nSTART, runs a requested
//                number of cycles (or until stopped), stops it via nSTOP and
//                checks the returned phases for legal one-hot cyclic order.
//  Ports       : clk  - system clock, all logic on posedge
//                rst  - synchronous reset, active-high
//                bus  - phase_sequence_master_if.master (commands, phases,
//                       nSTART/nSTOP, busy/done/err/err_code/cycle_count)
//  Parameters  : CNT_W   - width of cycle_target / cycle_count
//                TIMEOUT - max clocks in START/STOP before a timeout error
//  Revision    : 1.0  initial release
// ============================================================================
module phase_sequence_master #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  phase_sequence_master_if.master    bus
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] c_err_pattern = 2'b01;
  localparam logic [1:0] c_err_order   = 2'b10;
  localparam logic [1:0] c_err_timeout = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t           r_state;
  logic [2:0]       r_p_prev;
  logic [TO_W-1:0]  r_tcnt;
  logic [CNT_W-1:0] r_target;
  logic             r_stop_latch;
  logic             r_n_start;
  logic             r_n_stop;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_cycle_count;

  logic [2:0] w_p;
  logic       w_one_hot;
  logic [2:0] w_succ;
  logic       w_t3_entry;
  logic       w_stop_cond;
  logic       w_err_req;
  logic [1:0] w_err_code;

  assign w_p        = {bus.t3, bus.t2, bus.t1};
  assign w_one_hot  = (w_p == 3'b001) || (w_p == 3'b010) || (w_p == 3'b100);
  // The only legal next phase is the previous one rotated up by one.
  assign w_succ     = {r_p_prev[1:0], r_p_prev[2]};
  assign w_t3_entry = (w_p == 3'b100) && (r_p_prev != 3'b100);
  // A stop request arriving on the same edge as T2 entry still takes effect.
  assign w_stop_cond = r_stop_latch || bus.cmd_stop ||
                       ((r_target != '0) && ((r_cycle_count + CNT_W'(1)) == r_target));

  // Error detection is resolved first so it pre-empts any stop decision.
  always_comb begin
    w_err_req  = 1'b0;
    w_err_code = 2'b00;
    case (r_state)
      S_START: begin
        if ((w_p != 3'b000) && (w_p != 3'b001)) begin
          w_err_req  = 1'b1;
          w_err_code = w_one_hot ? c_err_order : c_err_pattern;
        end else if ((w_p == 3'b000) && (r_tcnt == c_to_last)) begin
          w_err_req  = 1'b1;
          w_err_code = c_err_timeout;
        end
      end
      S_RUN, S_STOP: begin
        // In STOP an all-zero vector is the clean completion, not an error.
        if (!((r_state == S_STOP) && (w_p == 3'b000))) begin
          if (!w_one_hot) begin
            w_err_req  = 1'b1;
            w_err_code = c_err_pattern;
          end else if (w_p != w_succ) begin
            w_err_req  = 1'b1;
            w_err_code = c_err_order;
          end else if ((r_state == S_STOP) && (r_tcnt == c_to_last)) begin
            w_err_req  = 1'b1;
            w_err_code = c_err_timeout;
          end
        end
      end
      default: begin
        w_err_req  = 1'b0;
        w_err_code = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_p_prev      <= 3'b000;
      r_tcnt        <= '0;
      r_target      <= '0;
      r_stop_latch  <= 1'b0;
      r_n_start     <= 1'b1;
      r_n_stop      <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'b00;
      r_cycle_count <= '0;
    end else begin
      r_p_prev <= w_p;
      r_done   <= 1'b0;

      if ((r_state == S_START || r_state == S_RUN) && bus.cmd_stop) begin
        r_stop_latch <= 1'b1;
      end

      if (w_err_req) begin
        r_state    <= S_ERROR;
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
        r_n_start  <= 1'b1;
        r_n_stop   <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.cmd_start && (w_p == 3'b000)) begin
              r_state       <= S_START;
              r_n_start     <= 1'b0;
              r_busy        <= 1'b1;
              r_cycle_count <= '0;
              r_target      <= bus.cycle_target;
              // A stop arriving with the start yields a single-cycle run.
              r_stop_latch  <= bus.cmd_stop;
              r_tcnt        <= '0;
            end
          end
          S_START: begin
            if (w_p == 3'b001) begin
              r_state   <= S_RUN;
              r_n_start <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
          S_RUN: begin
            if (w_t3_entry) begin
              r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            // Phase order is already verified, so P=010 here is a T2 entry.
            if ((w_p == 3'b010) && w_stop_cond) begin
              r_state  <= S_STOP;
              r_n_stop <= 1'b0;
              r_tcnt   <= '0;
            end
          end
          S_STOP: begin
            if (w_p == 3'b000) begin
              r_state  <= S_IDLE;
              r_n_stop <= 1'b1;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              if (w_t3_entry) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
              end
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
          default: begin
            // ERROR holds everything until reset.
          end
        endcase
      end
    end
  end

  assign bus.n_start     = r_n_start;
  assign bus.n_stop      = r_n_stop;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;
  assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequence_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequence_master
//  Description : Directed bench for phase_sequence_master with a simple
//                closed-loop sequencer model or forced phase vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_phase_sequence_master;

  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  logic loop_en;
  logic seq_clr;
  logic [2:0] seq_p;
  logic [2:0] force_p;
  logic [2:0] p;
  int passed;
  int total;

  phase_sequence_master_if #(.CNT_W(CNT_W)) intf ();

  phase_sequence_master #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign p       = loop_en ? seq_p : force_p;
  assign intf.t1 = p[0];
  assign intf.t2 = p[1];
  assign intf.t3 = p[2];

  // Sequencer model: 000 waits for nSTART low, rotates one phase per clock,
  // clears from T3 when nSTOP is low.
  always @(posedge clk) begin
    if (seq_clr)                              seq_p <= 3'b000;
    else if (seq_p == 3'b000) begin
      if (!intf.n_start)                      seq_p <= 3'b001;
    end
    else if (seq_p == 3'b100 && !intf.n_stop) seq_p <= 3'b000;
    else                                      seq_p <= {seq_p[1:0], seq_p[2]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (intf.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(intf.done), 32'd1);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    seq_clr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    seq_clr = 1'b0;
  endtask

  initial begin
    logic [5:0] exp1 [9];
    int done_cnt;
    passed = 0;
    total = 0;
    loop_en = 1'b1;
    force_p = 3'b000;
    intf.cmd_start = 1'b0;
    intf.cmd_stop = 1'b0;
    intf.cycle_target = '0;
    reset_all();

    // Reset values
    chk("rst_ctrl", 32'({intf.n_start, intf.n_stop, intf.busy, intf.done, intf.err, intf.err_code}), 32'b1100000);
    chk("rst_count", 32'(intf.cycle_count), 32'd0);

    // 1) closed loop, target 2: {p, n_stop, done, busy} after each edge
    exp1[0] = 6'b001_1_0_1; exp1[1] = 6'b010_1_0_1; exp1[2] = 6'b100_1_0_1;
    exp1[3] = 6'b001_1_0_1; exp1[4] = 6'b010_1_0_1; exp1[5] = 6'b100_0_0_1;
    exp1[6] = 6'b000_0_0_1; exp1[7] = 6'b000_1_1_0; exp1[8] = 6'b000_1_0_0;
    intf.cycle_target = 8'd2;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    chk("t1_start", 32'({intf.n_start, intf.busy}), 32'b01);
    done_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (intf.done === 1'b1) done_cnt++;
      chk($sformatf("t1_step%0d", k + 1), 32'({p, intf.n_stop, intf.done, intf.busy}), 32'(exp1[k]));
    end
    chk("t1_done_once", 32'(done_cnt), 32'd1);
    chk("t1_count", 32'(intf.cycle_count), 32'd2);
    chk("t1_err", 32'(intf.err), 32'd0);

    // 2) free run, stop requested during third T1
    intf.cycle_target = 8'd0;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("t2_third_t1", 32'(p), 32'b001);
    intf.cmd_stop = 1'b1;
    tick();
    intf.cmd_stop = 1'b0;
    wait_done("t2_done", 10);
    chk("t2_count", 32'(intf.cycle_count), 32'd3);
    chk("t2_err", 32'(intf.err), 32'd0);
    tick();
    chk("t2_done_pulse", 32'({intf.done, intf.busy}), 32'b00);

    // Start and stop together: one cycle run
    intf.cmd_start = 1'b1;
    intf.cmd_stop = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    intf.cmd_stop = 1'b0;
    wait_done("ss_done", 10);
    chk("ss_count", 32'(intf.cycle_count), 32'd1);
    tick();

    // 3) open loop, sequencer never answers
    loop_en = 1'b0;
    force_p = 3'b000;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    tick(); tick(); tick();
    chk("t3_pre_timeout", 32'({intf.err, intf.busy}), 32'b01);
    tick();
    chk("t3_timeout", 32'({intf.err, intf.err_code, intf.n_stop, intf.busy, intf.n_start}), 32'b111001);

    // 4a) non-one-hot phase in RUN
    reset_all();
    force_p = 3'b000;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    force_p = 3'b001; tick();
    chk("t4_run", 32'({intf.busy, intf.n_start}), 32'b11);
    force_p = 3'b010; tick();
    force_p = 3'b011; tick();
    chk("t4_pattern", 32'({intf.err, intf.err_code}), 32'b101);
    force_p = 3'b000;
    intf.cmd_start = 1'b1;
    tick(); tick();
    intf.cmd_start = 1'b0;
    chk("t4_ignored", 32'({intf.err, intf.err_code, intf.busy, intf.n_start, intf.n_stop}), 32'b101010);

    // 4b) skipped phase 001 -> 100
    reset_all();
    force_p = 3'b000;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    force_p = 3'b001; tick();
    force_p = 3'b100; tick();
    chk("t4_order", 32'({intf.err, intf.err_code}), 32'b110);

    // 5) reset mid-run, then start request with non-zero phase
    loop_en = 1'b1;
    reset_all();
    intf.cycle_target = 8'd0;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_midrun", 32'({intf.busy, intf.cycle_count}), 32'h101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ctrl", 32'({intf.n_start, intf.n_stop, intf.busy, intf.done, intf.err, intf.err_code}), 32'b1100000);
    chk("t5_rst_count", 32'(intf.cycle_count), 32'd0);
    loop_en = 1'b0;
    force_p = 3'b010;
    intf.cmd_start = 1'b1;
    tick(); tick();
    intf.cmd_start = 1'b0;
    chk("t5_start_ignored", 32'({intf.n_start, intf.busy}), 32'b10);

    // 6) single cycle with start re-pulsed while busy
    loop_en = 1'b1;
    reset_all();
    intf.cycle_target = 8'd1;
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    tick(); tick();
    intf.cmd_start = 1'b1;
    tick();
    intf.cmd_start = 1'b0;
    chk("t6_first_t3", 32'({p, intf.n_stop, intf.busy, intf.n_start}), 32'b100_0_1_1);
    tick();
    chk("t6_count", 32'(intf.cycle_count), 32'd1);
    tick();
    chk("t6_done", 32'(intf.done), 32'd1);
    tick(); tick();
    chk("t6_no_restart", 32'({p, intf.busy, intf.n_start}), 32'b000_0_1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
